// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller.
// Master 0 (VGA reader) wins ties from IDLE; an owner keeps the bus until it drops cyc.
module wshb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 32
) (
  input  logic                  fpga_CLK_AUX,
  input  logic                  n_rst,

  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADR_W-1:0]      m0_adr,
  input  logic [DATA_W-1:0]     m0_dat_w,
  input  logic [DATA_W/8-1:0]   m0_sel,
  output logic                  m0_ack,
  output logic                  m0_stall,
  output logic [DATA_W-1:0]     m0_dat_r,

  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADR_W-1:0]      m1_adr,
  input  logic [DATA_W-1:0]     m1_dat_w,
  input  logic [DATA_W/8-1:0]   m1_sel,
  output logic                  m1_ack,
  output logic                  m1_stall,
  output logic [DATA_W-1:0]     m1_dat_r,

  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADR_W-1:0]      s_adr,
  output logic [DATA_W-1:0]     s_dat_w,
  output logic [DATA_W/8-1:0]   s_sel,
  input  logic                  s_ack,
  input  logic                  s_stall,
  input  logic [DATA_W-1:0]     s_dat_r,

  output logic [1:0]            grant,
  output logic [15:0]           sw_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sw_count_q, sw_count_d;

  always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      sw_count_q <= '0;
    end else begin
      state_q    <= state_d;
      sw_count_q <= sw_count_d;
    end
  end

  // No preemption: the owner is only replaced once its cyc is low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc)      state_d = OWN0;
        else if (m1_cyc) state_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc) state_d = m1_cyc ? OWN1 : IDLE;
      end
      OWN1: begin
        if (!m1_cyc) state_d = m0_cyc ? OWN0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sw_count_d = sw_count_q;
    if ((state_d != state_q) && (state_d != IDLE)) sw_count_d = sw_count_q + 16'd1;
  end

  // Acks are gated with the owner's cyc so a response landing after it let go is dropped.
  always_comb begin
    grant    = 2'b00;
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_w  = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m0_stall = 1'b1;
    m0_dat_r = '0;
    m1_ack   = 1'b0;
    m1_stall = 1'b1;
    m1_dat_r = '0;
    case (state_q)
      OWN0: begin
        grant    = 2'b01;
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_w  = m0_dat_w;
        s_sel    = m0_sel;
        m0_ack   = m0_cyc & s_ack;
        m0_stall = s_stall;
        m0_dat_r = s_dat_r;
      end
      OWN1: begin
        grant    = 2'b10;
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_w  = m1_dat_w;
        s_sel    = m1_sel;
        m1_ack   = m1_cyc & s_ack;
        m1_stall = s_stall;
        m1_dat_r = s_dat_r;
      end
      default: ;
    endcase
  end

  assign sw_count = sw_count_q;

endmodule
